lsu_ctrl: RTL
=============

// Module: lsu_ctrl
// PURPOSE
//  Load/store unit: the initiator for the word-addressed data memory. Accepts one
//  byte-addressed CPU load/store at a time and drives Ad/WrData/MemWr/DMcut_sel.
//  Extracts and extends loaded sub-words itself. Uses read-modify-write for sub-word
//  stores the memory cannot write natively. Sits between execute stage and data memory.
// PARAMETERS
//  DM_WORDS  64  words in data memory
//  AW        6   word-index bits (log2 DM_WORDS)
// PORTS
//  Clk        in   1   clock, all state updates on posedge
//  Reset      in   1   asynchronous, active-high reset
//  req_valid  in   1   CPU request valid
//  req_ready  out  1   request accepted when req_valid&req_ready at posedge
//  req_we     in   1   1=store, 0=load
//  req_size   in   2   0=byte, 1=half, 2=word; 3=illegal
//  req_signed in   1   loads: sign-extend (1) / zero-extend (0)
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data, right-aligned
//  resp_valid out  1   one-cycle pulse, transaction complete
//  resp_rdata out  32  load result (0 for stores/errors)
//  resp_err   out  1   with resp_valid: misaligned/out-of-range/illegal size
//  Ad         out  32  word index to memory = {0, addr[AW+1:2]}
//  WrData     out  32  memory write data
//  MemWr      out  3   0=read, 1=word write, 2=byte[7:0], 4=half[15:0]
//  DMcut_sel  out  2   held at 0 (full word returned)
//  DM         in   32  memory read word, valid the cycle after Ad presented with MemWr=0
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; resp_valid/resp_err=0; resp_rdata, Ad, WrData = 0;
//  MemWr=0; DMcut_sel=0. Takes effect immediately, including mid-transaction.
//  No transaction is resumed after reset.
//  Memory outputs come only from state and latched request registers.
//  There is no combinational path from req_* to memory ports.
//  req_ready=1 only in IDLE. The request is latched on accept. req_* is ignored otherwise.
//  Errors, checked at accept, in priority order:
//   - size==3
//   - addr[31:AW+2]!=0
//   - half with addr[0]!=0
//   - word with addr[1:0]!=0
//   On error: go to DONE with resp_err=1. No memory access; MemWr stays 0.
//  FSM: IDLE, LD_ISSUE, LD_DATA, RMW_RD, RMW_MERGE, ST_WRITE, DONE.
//   IDLE -> LD_ISSUE on load.
//   IDLE -> ST_WRITE on store: word, byte at lane 0, or half at lane 0.
//   IDLE -> RMW_RD on store: byte at lane 1-3, or half at lane 2.
//   LD_ISSUE: MemWr=0, Ad valid. Next state LD_DATA.
//   LD_DATA: sample DM. Select lane by addr[1:0]; size sets byte/half/word.
//    Extend per req_signed. resp_rdata <= result; resp_valid=1. Next state IDLE.
//   RMW_RD: MemWr=0, Ad valid. Next state RMW_MERGE.
//   RMW_MERGE: merge reg <= DM with the target lane replaced by req_wdata low bits.
//    Next state ST_WRITE.
//   ST_WRITE: one cycle. MemWr=1 with merge reg (RMW) or word data.
//    Native lane-0 byte uses MemWr=2; native lane-0 half uses MemWr=4.
//    WrData holds the data. Next state DONE.
//   DONE: resp_valid=1 for one cycle, resp_rdata=0. Next state IDLE.
//  Latency, accept edge to resp_valid:
//   - load: 2 cycles
//   - native store: 2 cycles
//   - RMW store: 4 cycles
//   - error: 1 cycle
//  MemWr is nonzero only in ST_WRITE; exactly one write per store.
//  MemWr is 0 in all other states, so the memory performs idle reads there.
//  The next request can be accepted in the cycle resp_valid is high, since FSM is then in
//  IDLE the following cycle: no back-to-back overlap; throughput limited by latency.
// TESTING
//  1. Store word 0xDEADBEEF @0x10, load word @0x10
//     -> MemWr=1, Ad=4 for one cycle; load returns 0xDEADBEEF 2 cycles after accept.
//  2. Store byte 0xA5 @0x12 over word 0x11223344
//     -> RMW: reads Ad=4, writes 0x11A53344 with MemWr=1; resp 4 cycles after accept.
//  3. Mem[5]=0x8001FF80: load half signed @0x16 -> 0xFFFF8001.
//     Unsigned byte @0x14 -> 0x00000080.
//  4. Load word @0x13, half @0x01, addr 0x100, size=3
//     -> each resp_err=1 next cycle; MemWr never nonzero; resp_rdata=0.
//  5. Store byte 0x7E @0x20 (lane 0) -> MemWr=2, WrData[7:0]=0x7E, no read cycle.
//  6. Assert Reset during RMW_MERGE
//     -> MemWr=0 immediately, no write, no resp_valid; req_ready=1 after release.

Source files
------------

// File: rtl/lsu_ctrl_if.sv
// rtl/lsu_ctrl_if.sv - CPU request/response and data-memory port bundle for the load/store unit
interface lsu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] Ad;
    logic [31:0] WrData;
    logic [2:0]  MemWr;
    logic [1:0]  DMcut_sel;
    logic [31:0] DM;

    // slave: the load/store unit; master: CPU plus data memory around it
    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, DM,
        output req_ready, resp_valid, resp_rdata, resp_err, Ad, WrData, MemWr, DMcut_sel
    );
    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, DM,
        input  req_ready, resp_valid, resp_rdata, resp_err, Ad, WrData, MemWr, DMcut_sel
    );
endinterface

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store unit driving a word-addressed data memory, with sub-word extract and RMW stores
module lsu_ctrl #(
    parameter int DM_WORDS = 64,
    parameter int AW       = 6
) (
    input  logic     Clk,
    input  logic     Reset,
    lsu_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LD_ISSUE, S_LD_DATA, S_RMW_RD, S_RMW_MERGE, S_ST_WRITE, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    size_q;
    logic          signed_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   data_q;
    logic          err_q;
    logic          resp_valid_q;
    logic          resp_err_q;
    logic [31:0]   resp_rdata_q;

    logic          accept;
    logic          err_in;
    logic          native_in;
    logic [31:0]   store_in;
    logic [31:0]   merged;
    logic [31:0]   load_res;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;

    assign accept    = (state_q == S_IDLE) && bus.req_valid;
    assign native_in = (bus.req_size == 2'd2) || (bus.req_addr[1:0] == 2'b00);

    always_comb begin
        err_in = 1'b0;
        if (bus.req_size == 2'd3)
            err_in = 1'b1;
        else if ((bus.req_addr >> 2) >= 32'(DM_WORDS))
            err_in = 1'b1;
        else if (bus.req_size == 2'd1 && bus.req_addr[0])
            err_in = 1'b1;
        else if (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'b00)
            err_in = 1'b1;
    end

    always_comb begin
        store_in = bus.req_wdata;
        case (bus.req_size)
            2'd0:    store_in = {24'b0, bus.req_wdata[7:0]};
            2'd1:    store_in = {16'b0, bus.req_wdata[15:0]};
            default: store_in = bus.req_wdata;
        endcase
    end

    // Sub-word lanes are picked straight from the latched byte offset
    always_comb begin
        merged = bus.DM;
        if (size_q == 2'd0)
            merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
        else if (size_q == 2'd1)
            merged[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
    end

    always_comb begin
        byte_v   = bus.DM[{addr_q[1:0], 3'b000} +: 8];
        half_v   = bus.DM[{addr_q[1], 4'b0000} +: 16];
        load_res = bus.DM;
        if (size_q == 2'd0)
            load_res = {{24{signed_q & byte_v[7]}}, byte_v};
        else if (size_q == 2'd1)
            load_res = {{16{signed_q & half_v[15]}}, half_v};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (err_in)
                        state_d = S_DONE;
                    else if (!bus.req_we)
                        state_d = S_LD_ISSUE;
                    else if (native_in)
                        state_d = S_ST_WRITE;
                    else
                        state_d = S_RMW_RD;
                end
            end
            S_LD_ISSUE:  state_d = S_LD_DATA;
            S_LD_DATA:   state_d = S_IDLE;
            S_RMW_RD:    state_d = S_RMW_MERGE;
            S_RMW_MERGE: state_d = S_ST_WRITE;
            S_ST_WRITE:  state_d = S_DONE;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            size_q       <= 2'd0;
            signed_q     <= 1'b0;
            addr_q       <= '0;
            data_q       <= 32'd0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                size_q   <= bus.req_size;
                signed_q <= bus.req_signed;
                addr_q   <= bus.req_addr[AW+1:0];
                data_q   <= store_in;
                err_q    <= err_in;
            end else if (state_q == S_RMW_MERGE) begin
                data_q <= merged;
            end
            resp_valid_q <= (state_q == S_LD_DATA) || (state_q == S_DONE);
            resp_err_q   <= (state_q == S_DONE) && err_q;
            resp_rdata_q <= (state_q == S_LD_DATA) ? load_res : 32'd0;
        end
    end

    // Memory ports depend only on state and latched request, never on req_*
    always_comb begin
        bus.MemWr  = 3'd0;
        bus.WrData = 32'd0;
        if (state_q == S_ST_WRITE) begin
            bus.WrData = data_q;
            if (size_q == 2'd0 && addr_q[1:0] == 2'b00)
                bus.MemWr = 3'd2;
            else if (size_q == 2'd1 && addr_q[1] == 1'b0)
                bus.MemWr = 3'd4;
            else
                bus.MemWr = 3'd1;
        end
    end

    assign bus.Ad         = 32'(addr_q[AW+1:2]);
    assign bus.DMcut_sel  = 2'd0;
    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
endmodule
